// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the 4-bit ALU and the blocks that consume its outputs.
// The flag bit positions match the layout of the ALU o_flag vector.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH     = 4;
   localparam int FLAG_W        = 4;

   localparam int FLAG_ERR      = 0;
   localparam int FLAG_NEG      = 1;
   localparam int FLAG_POS      = 2;
   localparam int FLAG_OVERFLOW = 3;

endpackage : alu_pkg

// File: rtl/alu_sat_counter.sv
// -----------------------------------------------------------------------------
// alu_sat_counter
// Saturating event counter. It counts up by one per cycle with i_inc high, and
// it holds at all-ones instead of wrapping. i_clr zeroes the count on the next
// edge and takes priority over a simultaneous increment.
//
// Ports
//   s_CLK   in   clock, rising edge
//   s_RSTn  in   asynchronous reset, active-high
//   i_clr   in   synchronous clear
//   i_inc   in   increment request
//   o_cnt   out  current count (CNT_W bits)
// -----------------------------------------------------------------------------
module alu_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             s_CLK,
   input  logic             s_RSTn,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge s_CLK or posedge s_RSTn) begin
      if (s_RSTn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule : alu_sat_counter

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// This is the capture stage behind the ALU. Every valid result/flag pair goes
// into a show-ahead FIFO and is offered to a consumer. Saturating counters
// track the error flags, the overflow flags and the dropped samples.
//
// Handshake: the head entry transfers on a rising edge when o_valid and i_ready
// are both high. o_valid does not depend on i_ready. The ALU side cannot stall,
// so o_ready (~full) is only informative. When the FIFO is full, an incoming
// sample is still accepted if a pop happens in the same cycle. Otherwise it is
// dropped, and o_drop pulses.
//
// Ports
//   s_CLK, s_RSTn          clock, asynchronous active-high reset
//   i_valid/i_result/i_flag ALU sample in
//   o_ready                 not full
//   o_valid/o_result/o_flag head entry out (zero when empty)
//   i_ready                 consumer accepts head
//   o_level                 occupancy
//   o_drop                  combinational pulse for a discarded sample
//   i_clr                   synchronous clear of all counters
//   o_err_cnt/o_ovf_cnt/o_drop_cnt saturating event counters
// -----------------------------------------------------------------------------
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     s_CLK,
   input  logic                     s_RSTn,
   input  logic                     i_valid,
   input  logic [WIDTH-1:0]         i_result,
   input  logic [FLAG_W-1:0]        i_flag,
   output logic                     o_ready,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [WIDTH-1:0]         o_result,
   output logic [FLAG_W-1:0]        o_flag,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_drop,
   input  logic                     i_clr,
   output logic [CNT_W-1:0]         o_err_cnt,
   output logic [CNT_W-1:0]         o_ovf_cnt,
   output logic [CNT_W-1:0]         o_drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = WIDTH + FLAG_W;

   // Each entry is stored as {result, flag}.
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;

   logic full, empty, push, pop, drop;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == '0);
   assign pop   = ~empty & i_ready;
   assign push  = i_valid & (~full | pop);
   assign drop  = i_valid & full & ~pop;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
   end

   always_ff @(posedge s_CLK or posedge s_RSTn) begin
      if (s_RSTn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // The storage is not reset. The head output is masked while empty, so stale
   // contents never reach the consumer.
   always_ff @(posedge s_CLK) begin
      if (push) mem_q[wr_ptr_q] <= {i_result, i_flag};
   end

   assign o_ready  = ~full;
   assign o_valid  = ~empty;
   assign o_level  = level_q;
   assign o_drop   = drop;
   assign o_result = empty ? '0 : mem_q[rd_ptr_q][ENT_W-1:FLAG_W];
   assign o_flag   = empty ? '0 : mem_q[rd_ptr_q][FLAG_W-1:0];

   alu_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .s_CLK  (s_CLK),
      .s_RSTn (s_RSTn),
      .i_clr  (i_clr),
      .i_inc  (push & i_flag[FLAG_ERR]),
      .o_cnt  (o_err_cnt)
   );

   alu_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
      .s_CLK  (s_CLK),
      .s_RSTn (s_RSTn),
      .i_clr  (i_clr),
      .i_inc  (push & i_flag[FLAG_OVERFLOW]),
      .o_cnt  (o_ovf_cnt)
   );

   alu_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .s_CLK  (s_CLK),
      .s_RSTn (s_RSTn),
      .i_clr  (i_clr),
      .i_inc  (drop),
      .o_cnt  (o_drop_cnt)
   );

endmodule : alu_result_fifo

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
// Directed bench for alu_result_fifo with WIDTH=4, DEPTH=4 and CNT_W=8.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, which shows
// the state registered at the previous rising edge and the combinational o_drop.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             s_CLK;
   logic             s_RSTn;
   logic             i_valid;
   logic [WIDTH-1:0] i_result;
   logic [3:0]       i_flag;
   logic             o_ready;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic [3:0]       o_flag;
   logic [2:0]       o_level;
   logic             o_drop;
   logic             i_clr;
   logic [CNT_W-1:0] o_err_cnt;
   logic [CNT_W-1:0] o_ovf_cnt;
   logic [CNT_W-1:0] o_drop_cnt;

   int checks = 0;
   int errors = 0;

   alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .s_CLK      (s_CLK),
      .s_RSTn     (s_RSTn),
      .i_valid    (i_valid),
      .i_result   (i_result),
      .i_flag     (i_flag),
      .o_ready    (o_ready),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_result   (o_result),
      .o_flag     (o_flag),
      .o_level    (o_level),
      .o_drop     (o_drop),
      .i_clr      (i_clr),
      .o_err_cnt  (o_err_cnt),
      .o_ovf_cnt  (o_ovf_cnt),
      .o_drop_cnt (o_drop_cnt)
   );

   // Clock
   initial s_CLK = 1'b0;
   always #5 s_CLK = ~s_CLK;

   typedef struct {
      logic       v;
      logic [3:0] res;
      logic [3:0] flg;
      logic       rdy;
      logic       clr;
      int         e_valid;
      int         e_res;
      int         e_flag;
      int         e_level;
      int         e_ready;
      int         e_drop;
      int         e_dcnt;
      int         e_err;
      int         e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic v, input int res, input int flg,
                          input logic rdy, input logic clr,
                          input int ev, input int eres, input int eflg,
                          input int elvl, input int erdy, input int edrop,
                          input int edc, input int eerr, input int eovf);
      vec_t t;
      t.v = v; t.res = 4'(res); t.flg = 4'(flg); t.rdy = rdy; t.clr = clr;
      t.e_valid = ev; t.e_res = eres; t.e_flag = eflg; t.e_level = elvl;
      t.e_ready = erdy; t.e_drop = edrop; t.e_dcnt = edc;
      t.e_err = eerr; t.e_ovf = eovf;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input int res, input int flg,
                        input logic rdy, input logic clr);
      i_valid  = v;
      i_result = 4'(res);
      i_flag   = 4'(flg);
      i_ready  = rdy;
      i_clr    = clr;
   endtask

   initial begin
      s_RSTn = 1'b1;
      drive(0, 0, 0, 0, 0);

      //        v res flg rdy clr | val res flg lvl rdy drop dcnt err ovf
      // Idle right after reset.
      add_vec(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);
      // Single write 2 / 0100, then a pop.
      add_vec(1, 2, 4, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);
      add_vec(0, 0, 0, 0, 0,   1, 2, 4, 1, 1, 0, 0, 0, 0);
      add_vec(0, 0, 0, 1, 0,   1, 2, 4, 1, 1, 0, 0, 0, 0);
      add_vec(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);
      // Five writes 1..5 into a 4-deep FIFO, the fifth is dropped.
      add_vec(1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);
      add_vec(1, 2, 0, 0, 0,   1, 1, 0, 1, 1, 0, 0, 0, 0);
      add_vec(1, 3, 0, 0, 0,   1, 1, 0, 2, 1, 0, 0, 0, 0);
      add_vec(1, 4, 0, 0, 0,   1, 1, 0, 3, 1, 0, 0, 0, 0);
      add_vec(1, 5, 0, 0, 0,   1, 1, 0, 4, 0, 1, 0, 0, 0);
      // Drain gives 1,2,3,4 in order.
      add_vec(0, 0, 0, 1, 0,   1, 1, 0, 4, 0, 0, 1, 0, 0);
      add_vec(0, 0, 0, 1, 0,   1, 2, 0, 3, 1, 0, 1, 0, 0);
      add_vec(0, 0, 0, 1, 0,   1, 3, 0, 2, 1, 0, 1, 0, 0);
      add_vec(0, 0, 0, 1, 0,   1, 4, 0, 1, 1, 0, 1, 0, 0);
      add_vec(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1, 0, 0);
      // Fill with 6..9, then write 9/1001 while popping: it is accepted.
      add_vec(1, 6, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1, 0, 0);
      add_vec(1, 7, 0, 0, 0,   1, 6, 0, 1, 1, 0, 1, 0, 0);
      add_vec(1, 8, 0, 0, 0,   1, 6, 0, 2, 1, 0, 1, 0, 0);
      add_vec(1, 9, 0, 0, 0,   1, 6, 0, 3, 1, 0, 1, 0, 0);
      add_vec(1, 9, 9, 1, 0,   1, 6, 0, 4, 0, 0, 1, 0, 0);
      add_vec(0, 0, 0, 1, 0,   1, 7, 0, 4, 0, 0, 1, 1, 1);
      add_vec(0, 0, 0, 1, 0,   1, 8, 0, 3, 1, 0, 1, 1, 1);
      add_vec(0, 0, 0, 1, 0,   1, 9, 0, 2, 1, 0, 1, 1, 1);
      add_vec(0, 0, 0, 1, 0,   1, 9, 9, 1, 1, 0, 1, 1, 1);
      add_vec(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1, 1, 1);
      // Counter clear.
      add_vec(0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1, 1, 1);
      add_vec(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);
      // Empty + push + i_ready: the pop is ignored.
      add_vec(1, 5, 2, 1, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);
      add_vec(0, 0, 0, 0, 0,   1, 5, 2, 1, 1, 0, 0, 0, 0);
      add_vec(0, 0, 0, 1, 0,   1, 5, 2, 1, 1, 0, 0, 0, 0);
      add_vec(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);

      repeat (2) @(negedge s_CLK);
      s_RSTn = 1'b0;

      foreach (vecs[i]) begin
         @(negedge s_CLK);
         drive(vecs[i].v, int'(vecs[i].res), int'(vecs[i].flg), vecs[i].rdy, vecs[i].clr);
         #1;
         check($sformatf("v%0d valid", i),  int'(o_valid),    vecs[i].e_valid);
         check($sformatf("v%0d result", i), int'(o_result),   vecs[i].e_res);
         check($sformatf("v%0d flag", i),   int'(o_flag),     vecs[i].e_flag);
         check($sformatf("v%0d level", i),  int'(o_level),    vecs[i].e_level);
         check($sformatf("v%0d ready", i),  int'(o_ready),    vecs[i].e_ready);
         check($sformatf("v%0d drop", i),   int'(o_drop),     vecs[i].e_drop);
         check($sformatf("v%0d dropcnt", i), int'(o_drop_cnt), vecs[i].e_dcnt);
         check($sformatf("v%0d errcnt", i), int'(o_err_cnt),  vecs[i].e_err);
         check($sformatf("v%0d ovfcnt", i), int'(o_ovf_cnt),  vecs[i].e_ovf);
      end

      // 300 accepted writes with flag 1001 saturate err and ovf at 255.
      for (int i = 0; i < 300; i++) begin
         @(negedge s_CLK);
         drive(1, i % 16, 9, 1, 0);
      end
      @(negedge s_CLK);
      // Clear together with a flagged, accepted write.
      drive(1, 3, 9, 1, 1);
      #1;
      check("sat errcnt", int'(o_err_cnt), 255);
      check("sat ovfcnt", int'(o_ovf_cnt), 255);
      check("sat dropcnt", int'(o_drop_cnt), 0);
      check("sat level", int'(o_level), 1);
      @(negedge s_CLK);
      drive(0, 0, 0, 0, 0);
      #1;
      check("clr errcnt", int'(o_err_cnt), 0);
      check("clr ovfcnt", int'(o_ovf_cnt), 0);
      check("clr level", int'(o_level), 1);
      check("clr head", int'(o_result), 3);
      @(negedge s_CLK);
      drive(0, 0, 0, 1, 0);
      @(negedge s_CLK);
      drive(0, 0, 0, 0, 0);
      #1;
      check("drain level", int'(o_level), 0);

      // Store three entries, then apply reset in the middle of a cycle.
      for (int i = 0; i < 3; i++) begin
         @(negedge s_CLK);
         drive(1, 12 + i, 9, 0, 0);
      end
      @(negedge s_CLK);
      drive(0, 0, 0, 0, 0);
      #1;
      check("pre-rst level", int'(o_level), 3);
      check("pre-rst errcnt", int'(o_err_cnt), 3);
      #1;
      s_RSTn = 1'b1;
      #1;
      check("rst valid", int'(o_valid), 0);
      check("rst level", int'(o_level), 0);
      check("rst ready", int'(o_ready), 1);
      check("rst result", int'(o_result), 0);
      check("rst errcnt", int'(o_err_cnt), 0);
      check("rst ovfcnt", int'(o_ovf_cnt), 0);
      @(negedge s_CLK);
      s_RSTn = 1'b0;
      @(negedge s_CLK);
      drive(1, 10, 1, 0, 0);
      @(negedge s_CLK);
      drive(1, 11, 0, 0, 0);
      @(negedge s_CLK);
      drive(0, 0, 0, 1, 0);
      #1;
      check("post-rst level", int'(o_level), 2);
      check("post-rst head0", int'(o_result), 10);
      check("post-rst flag0", int'(o_flag), 1);
      check("post-rst errcnt", int'(o_err_cnt), 1);
      @(negedge s_CLK);
      drive(0, 0, 0, 0, 0);
      #1;
      check("post-rst head1", int'(o_result), 11);
      check("post-rst level1", int'(o_level), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_alu_result_fifo

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream capture stage for the 4-bit ALU `TOP` (`UTOP`). It buffers each valid `o_result`/`o_flag` pair from the ALU in a small show-ahead FIFO and presents it to the consumer with a valid/ready handshake. It also keeps saturating event counters for error flags, overflow flags and dropped samples. It sits between `UTOP` and any result sink: a checker, output register bank or future serializer.

## Interface
- `WIDTH`, 4: result width; must match the ALU `WIDTH`.
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `CNT_W`, 8: width of each event counter.

- `s_CLK`  in  1  system clock, rising edge.
- `s_RSTn`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  ALU result present this cycle.
- `i_result`  in  WIDTH  ALU `o_result`.
- `i_flag`  in  4  ALU `o_flag`: bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW.
- `o_ready`  out  1  space available (`~full`), informative only; the ALU cannot stall.
- `o_valid`  out  1  head entry available.
- `i_ready`  in  1  consumer accepts the head entry.
- `o_result`  out  WIDTH  head result.
- `o_flag`  out  4  head flags.
- `o_level`  out  $clog2(DEPTH)+1  current occupancy.
- `o_drop`  out  1  one-cycle pulse when a sample is discarded.
- `i_clr`  in  1  synchronous clear of all counters.
- `o_err_cnt`, `o_ovf_cnt`, `o_drop_cnt`  out  CNT_W  saturating counters.

## Operation
- Storage: DEPTH × (WIDTH+4) register array, with read pointer, write pointer and occupancy count.
- Pop: `pop = o_valid & i_ready`.
- Push:
  - `push = i_valid & (~full | pop)`.
  - When full, a push is accepted only in the same cycle as a pop.
- Drop: `drop = i_valid & full & ~pop`.
  - The sample is discarded.
  - `o_drop` pulses for that cycle.
  - `o_drop_cnt` increments.
- Occupancy:
  - Level updates by +push −pop.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- Head output is show-ahead:
  - `o_result`/`o_flag` are driven from the array at the read pointer.
  - They are forced to 0 when empty.
- `o_valid = (level != 0)`.
- `o_err_cnt`: +1 per *accepted* push with `i_flag[0]`=1.
- `o_ovf_cnt`: +1 per accepted push with `i_flag[3]`=1.
- Counter saturation: all counters stop at 2^CNT_W−1 with no wrap.
- `i_clr`:
  - Zeroes all three counters on the next edge.
  - `i_clr` wins over a simultaneous increment.
  - FIFO contents are untouched.
- Flags are stored verbatim; the block does no recomputation.

## Timing
- Reset (async assert, sync-safe deassert): level=0, pointers=0, `o_valid`=0, `o_ready`=1, `o_result`=0, `o_flag`=0, `o_drop`=0, all counters 0.
- Reset mid-operation flushes all stored entries immediately.
- Latency: a push at edge N gives `o_valid`=1 with that data after edge N, i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- `o_ready`, `o_level`, `o_valid` are derived from registered state, with no combinational path from `i_valid`.
- `o_drop` is combinational from `i_valid`, full and pop.
- Empty + push + `i_ready`: the pop is ignored (`o_valid`=0); the entry appears next cycle.

## Structure
- Shared package `alu_pkg`: flag positions `FLAG_ERR`=0, `FLAG_NEG`=1, `FLAG_POS`=2, `FLAG_OVERFLOW`=3; `ALU_WIDTH`=4; the flag-vector width constant 4.
- Sub-module `alu_sat_counter` (params `CNT_W`; ports clk, rst, `i_clr`, `i_inc`, `o_cnt`), instantiated three times.
- FIFO control is inline: pointers, level, push/pop logic.

## Test plan
- Reset release, idle: `o_valid`=0, `o_ready`=1, `o_level`=0, counters 0, outputs 0.
- Single write of result 4'b0010, flag 4'b0100 with `i_ready`=0: next cycle `o_valid`=1, `o_result`=2, `o_flag`=4'b0100, `o_level`=1; with `i_ready`=1 one cycle later, `o_level`=0.
- Five consecutive writes 1..5, `i_ready`=0, DEPTH=4: `o_level`=4 and `o_ready`=0 after the 4th; the 5th gives an `o_drop` pulse and `o_drop_cnt`=1; draining yields 1,2,3,4 in order.
- Full FIFO, write 4'b1001 with `i_ready`=1 in the same cycle: the write is accepted, no drop, `o_level` stays 4, and the value exits after the 3 remaining older entries.
- 300 accepted writes with flag 4'b1001, CNT_W=8: `o_err_cnt`=`o_ovf_cnt`=255 (saturated); `i_clr` plus a flagged write in the same cycle leaves both counters at 0.
- Assert `s_RSTn` with 3 entries stored: in the same cycle `o_valid`=0, `o_level`=0 and counters 0; after release, normal writes resume from pointer 0.
